// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Raster-to-window stage: accepts one S-bit pixel per handshake in raster
// order and emits the 3x3 neighbourhood of every interior pixel as one
// packed 9*S-bit word, through a single registered output stage.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   data_in     pixel, raster order
//   in_valid    data_in valid
//   sof         start of frame, qualified by in_valid
//   in_ready    pixel accepted when in_valid && in_ready
//   data_out    window; p(r,c) at bits [(3r+c)*S +: S], r=0 top, c=0 left
//   out_valid   data_out holds a window
//   out_ready   downstream accepts the window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int S     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [S-1:0]   data_in,
  input  logic           in_valid,
  input  logic           sof,
  output logic           in_ready,
  output logic [9*S-1:0] data_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_e;
  logic [RW-1:0] row_q, row_d, row_e;

  // LB0 holds line row-1, LB1 holds line row-2. Not reset: the row/col >= 2
  // emit rule guarantees stale entries never reach an emitted window.
  logic [S-1:0] lb0_q [IMG_W];
  logic [S-1:0] lb1_q [IMG_W];
  logic [S-1:0] lb_a, lb_b;

  // Packed [row][col][bits]; flattening gives p(r,c) at (3r+c)*S directly.
  logic [2:0][2:0][S-1:0] win_q, win_d;

  logic           accept, emit, last_px;
  logic [9*S-1:0] dout_q;
  logic           ov_q, fd_q;

  assign in_ready   = !ov_q || out_ready;
  assign data_out   = dout_q;
  assign out_valid  = ov_q;
  assign frame_done = fd_q;

  always_comb begin
    accept = in_valid && in_ready;
    // sof forces the accepted pixel to (0,0) regardless of counter state.
    col_e  = sof ? '0 : col_q;
    row_e  = sof ? '0 : row_q;
    lb_a   = lb1_q[col_e];
    lb_b   = lb0_q[col_e];

    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_a;
      win_d[1][2] = lb_b;
      win_d[2][2] = data_in;
    end

    emit    = accept && (col_e >= CW'(2)) && (row_e >= RW'(2));
    last_px = (col_e == CW'(IMG_W-1)) && (row_e == RW'(IMG_H-1));

    col_d = col_e + CW'(1);
    row_d = row_e;
    if (col_e == CW'(IMG_W-1)) begin
      col_d = '0;
      row_d = (row_e == RW'(IMG_H-1)) ? '0 : row_e + RW'(1);
    end
  end

  // Storage without reset: line buffers and window shift register.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_e] <= lb_b;
      lb0_q[col_e] <= data_in;
      win_q        <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      ov_q   <= 1'b0;
      fd_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      fd_q <= accept && last_px;
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      // A new window and consumption of the old one may share an edge;
      // the load wins so out_valid stays high.
      if (emit) begin
        dout_q <= win_d;
        ov_q   <= 1'b1;
      end else if (out_ready) begin
        ov_q   <= 1'b0;
      end
    end
  end

endmodule
